mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single read/write port (port A) of the 4 KiB CPU memory between three requesters:
//  CPU core (cpu_), sprite blitter (blt_) and ROM loader (ldr_).
//  Issues at most one access per clock. Returns read data with the memory's fixed 1-cycle latency.
//  Flags writes into the write-protected font/reset area below 0x200.
//  Sits between the requesters and the memory port A pins; port B (video) is untouched.
// PARAMETERS
//  ADDR_W    12      address width (4096 bytes)
//  DATA_W    8       data width
//  MAX_WAIT  8       cycles a waiting blt/ldr request may be blocked before it is force-granted
//  MAX_LOCK  16      max consecutive locked beats for one owner
//  WP_LIMIT  12'h200 writes with addr < WP_LIMIT are dropped by memory and flagged
// PORTS
//  clk                         in   1       system clock (memory port A clock)
//  reset                       in   1       synchronous, active-high
//  {cpu,blt,ldr}_req           in   1 each  access request; addr/we/wdata/lock held stable until gnt
//  {cpu,blt,ldr}_we            in   1 each  1=write, 0=read
//  {cpu,blt,ldr}_lock          in   1 each  keep ownership for the next beat (Fx55/Fx65, sprite rows)
//  {cpu,blt,ldr}_addr          in   ADDR_W  byte address
//  {cpu,blt,ldr}_wdata         in   DATA_W  write data
//  {cpu,blt,ldr}_gnt           out  1 each  combinational; access issued this cycle
//  {cpu,blt,ldr}_rvalid        out  1 each  read data valid for that requester (cycle after gnt)
//  rdata                       out  DATA_W  shared read data = mem_rdata
//  mem_en, mem_write           out  1       to memory a_en / a_write
//  mem_addr                    out  ADDR_W  to memory a_addr
//  mem_wdata                   out  DATA_W  to memory a_in
//  mem_rdata                   in   DATA_W  from memory a_out (registered, 1-cycle latency)
//  wp_err                      out  1       1-cycle pulse, cycle after a granted write below WP_LIMIT
// BEHAVIOUR
//  Reset values (registers): rvalids=0, wp_err=0, lock owner=NONE, lock_cnt=0, rr_ptr=BLT, wait counters=0.
//  Outputs during reset: gnt*=0 and mem_en=0 while reset high.
//  Grant: at most one gnt per cycle. mem_en = |gnt. mem_* are muxed from the granted requester.
//  Grant priority, evaluated each cycle:
//   1. lock owner, if its req=1 and lock_cnt < MAX_LOCK;
//   2. starving blt/ldr (wait_cnt == MAX_WAIT) with req=1; if both starve, rr_ptr decides;
//   3. cpu_req;
//   4. blt/ldr by round-robin rr_ptr. rr_ptr flips to the other requester after each blt/ldr grant.
//  Lock:
//   - Granted beat with lock=1: owner <= granter, lock_cnt += 1.
//   - Granted beat with lock=0, owner req=0, or lock_cnt reaching MAX_LOCK: owner <= NONE, lock_cnt <= 0.
//   - After a MAX_LOCK release, the former owner is lowest priority for one cycle.
//  Wait counters (blt, ldr): increment (saturating at MAX_WAIT) while req=1 && !gnt; clear on gnt or req=0.
//   - CPU has no counter; CPU waits at most MAX_LOCK beats plus one forced beat per low requester.
//  Read return:
//   - Requester's rvalid=1 exactly one cycle after its read gnt; rdata valid that cycle only.
//   - Writes produce no rvalid.
//   - Back-to-back reads from different requesters are allowed. rvalid is tracked by a 2-bit registered id.
//  Write protect: writes with addr < WP_LIMIT are still issued (memory drops them); wp_err pulses next cycle.
//  Reset mid-operation: a read granted in the cycle reset asserts produces no rvalid; lock is dropped.
//  A requester dropping req without gnt is legal (request withdrawn, no side effects).
// STRUCTURE
//  Shared package chip8_pkg:
//   - requester ids REQ_NONE=0, REQ_CPU=1, REQ_BLT=2, REQ_LDR=3;
//   - ADDR_W/DATA_W, WP_LIMIT = 12'h200.
//  Sub-module arb_wait_ctr (saturating wait counter, instantiated for blt and ldr).
//  Grant logic and return tracking stay inline.
// TESTING
//  1. cpu read 0x200 alone -> cpu_gnt same cycle, mem_en=1, mem_addr=0x200; cpu_rvalid=1 next cycle with preloaded 0xA5.
//  2. cpu_req held high, blt_req high -> blt_gnt no later than cycle MAX_WAIT+1 (9); cpu stalls exactly 1 cycle.
//  3. blt and ldr both requesting continuously, cpu idle -> grants alternate BLT,LDR,BLT,LDR...
//  4. ldr 20 writes with lock=1 from 0x300, cpu requesting:
//     - 16 consecutive ldr_gnt, then cpu_gnt, then ldr resumes;
//     - read-back gives the written values.
//  5. blt write 0x050 data 0xFF -> wp_err pulse next cycle; read 0x050 returns original font byte.
//  6. reset asserted in the cycle of a cpu read gnt -> no cpu_rvalid; all gnt=0 during reset; lock owner NONE after.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem.
//   ADDR_W / DATA_W : CPU memory geometry (4 KiB x 8)
//   WP_LIMIT        : writes below this address hit the font/reset area and are dropped
//   req_id_e        : requester identifiers used by the port A arbiter
package chip8_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] WP_LIMIT = 12'h200;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_BLT  = 2'd2,
    REQ_LDR  = 2'd3
  } req_id_e;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating wait counter for one low-priority requester of the port A arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req_i      : requester is asking for the port
//   gnt_i      : requester was granted this cycle
//   starve_o   : requester has waited MAX_WAIT cycles and is still asking
module arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic gnt_i,
  output logic starve_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts only blocked cycles; a grant or a withdrawn request starts over.
  always_comb begin
    cnt_d = '0;
    if (req_i && !gnt_i) begin
      cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = req_i && (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for port A of the 4 KiB CPU memory, shared by the CPU core (cpu_),
// the sprite blitter (blt_) and the ROM loader (ldr_).
// Ports:
//   clk, reset                    : memory port A clock, synchronous active-high reset
//   {cpu,blt,ldr}_req/we/lock     : request, write enable, keep-ownership for next beat
//   {cpu,blt,ldr}_addr/wdata      : access address and write data (stable until gnt)
//   {cpu,blt,ldr}_gnt             : combinational, access issued this cycle
//   {cpu,blt,ldr}_rvalid          : read data valid, one cycle after a read grant
//   rdata                         : shared read data (straight from mem_rdata)
//   mem_en/mem_write/mem_addr/mem_wdata/mem_rdata : memory port A pins
//   wp_err                        : one-cycle pulse after a granted write below WP_LIMIT
module mem_port_arbiter
  import chip8_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              blt_req,
  input  logic              blt_we,
  input  logic              blt_lock,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [DATA_W-1:0] blt_wdata,
  output logic              blt_gnt,
  output logic              blt_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wp_err
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] MAX_LOCK_C = LCW'(MAX_LOCK);

  req_id_e        owner_q, owner_d;    // current lock owner
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  req_id_e        rr_q, rr_d;          // which of blt/ldr wins the next tie
  req_id_e        pen_q, pen_d;        // requester demoted for one cycle after a forced unlock
  req_id_e        rid_q, rid_d;        // who gets read data this cycle
  logic           wp_err_q, wp_err_d;

  req_id_e        gnt_id;
  logic           gnt_lock;
  logic [LCW-1:0] cnt_next;
  logic [3:0]     req_vec;             // indexed by req_id_e, bit 0 unused
  logic [3:0]     elig;                // req_vec with the demoted requester removed
  logic           st_blt, st_ldr;

  // Starvation counters for the two low-priority requesters (index 0 = blt, 1 = ldr).
  logic [1:0] lo_req, lo_gnt, lo_starve;
  assign lo_req = {ldr_req, blt_req};
  assign lo_gnt = {ldr_gnt, blt_gnt};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wait
      arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (lo_req[gi]),
        .gnt_i    (lo_gnt[gi]),
        .starve_o (lo_starve[gi])
      );
    end
  endgenerate

  // Grant selection. The demoted requester is only served when nobody else asks.
  always_comb begin
    gnt_id  = REQ_NONE;
    req_vec = {ldr_req, blt_req, cpu_req, 1'b0};
    elig    = req_vec;
    if (pen_q != REQ_NONE) begin
      elig[pen_q] = 1'b0;
    end
    st_blt = lo_starve[0] && elig[REQ_BLT];
    st_ldr = lo_starve[1] && elig[REQ_LDR];

    if (owner_q != REQ_NONE && req_vec[owner_q] && lock_cnt_q < MAX_LOCK_C) begin
      gnt_id = owner_q;
    end else if (st_blt && st_ldr) begin
      gnt_id = rr_q;
    end else if (st_blt) begin
      gnt_id = REQ_BLT;
    end else if (st_ldr) begin
      gnt_id = REQ_LDR;
    end else if (elig[REQ_CPU]) begin
      gnt_id = REQ_CPU;
    end else if (elig[REQ_BLT] && elig[REQ_LDR]) begin
      gnt_id = rr_q;
    end else if (elig[REQ_BLT]) begin
      gnt_id = REQ_BLT;
    end else if (elig[REQ_LDR]) begin
      gnt_id = REQ_LDR;
    end else if (pen_q != REQ_NONE && req_vec[pen_q]) begin
      gnt_id = pen_q;
    end

    // Nothing reaches the memory while reset is held.
    if (reset) begin
      gnt_id = REQ_NONE;
    end
  end

  // Port A mux from the granted requester.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt_lock  = 1'b0;
    case (gnt_id)
      REQ_CPU: begin
        mem_write = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        gnt_lock  = cpu_lock;
      end
      REQ_BLT: begin
        mem_write = blt_we;
        mem_addr  = blt_addr;
        mem_wdata = blt_wdata;
        gnt_lock  = blt_lock;
      end
      REQ_LDR: begin
        mem_write = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        gnt_lock  = ldr_lock;
      end
      default: ;
    endcase
  end

  assign mem_en  = (gnt_id != REQ_NONE);
  assign cpu_gnt = (gnt_id == REQ_CPU);
  assign blt_gnt = (gnt_id == REQ_BLT);
  assign ldr_gnt = (gnt_id == REQ_LDR);

  // Next state: lock ownership, round-robin pointer, read-return id, write-protect flag.
  // Any cycle without a locked grant (including the owner withdrawing) drops the lock.
  always_comb begin
    owner_d    = REQ_NONE;
    lock_cnt_d = '0;
    pen_d      = REQ_NONE;
    rr_d       = rr_q;
    rid_d      = REQ_NONE;
    wp_err_d   = 1'b0;
    cnt_next   = LCW'(1);
    if (gnt_id != REQ_NONE) begin
      if (gnt_id == owner_q) begin
        cnt_next = lock_cnt_q + LCW'(1);
      end
      if (gnt_lock) begin
        if (cnt_next == MAX_LOCK_C) begin
          pen_d = gnt_id;
        end else begin
          owner_d    = gnt_id;
          lock_cnt_d = cnt_next;
        end
      end
      if (!mem_write) begin
        rid_d = gnt_id;
      end
      wp_err_d = mem_write && (mem_addr < WP_LIMIT);
      if (gnt_id == REQ_BLT) begin
        rr_d = REQ_LDR;
      end else if (gnt_id == REQ_LDR) begin
        rr_d = REQ_BLT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= REQ_NONE;
      lock_cnt_q <= '0;
      rr_q       <= REQ_BLT;
      pen_q      <= REQ_NONE;
      rid_q      <= REQ_NONE;
      wp_err_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rr_q       <= rr_d;
      pen_q      <= pen_d;
      rid_q      <= rid_d;
      wp_err_q   <= wp_err_d;
    end
  end

  assign cpu_rvalid = (rid_q == REQ_CPU);
  assign blt_rvalid = (rid_q == REQ_BLT);
  assign ldr_rvalid = (rid_q == REQ_LDR);
  assign rdata      = mem_rdata;
  assign wp_err     = wp_err_q;

endmodule
